result_frame_tx: RTL and testbench

- Downstream stage of the matrix processor array; sits between the processor result output and the UART transmitter.
- Buffers N result bytes for one operation and frames them into a response packet: header, length, command, data, footer.
- Streams the packet byte-by-byte to the UART TX over a valid/ready handshake.
- Applies back-pressure to the processors while a frame is being sent.

---
 rtl/result_frame_tx.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_result_frame_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_tx.sv
// -----------------------------------------------------------------------------
// result_frame_tx
//
// Purpose: buffers up to MAX_N result bytes from the processor array and
// streams them to the UART transmitter as a response frame:
//   HDR, LEN (= n+1), CMD_RES, data[0..n-1], [CSUM], FTR
// Results are back-pressured (res_ready=0) while a frame is being sent.
//
// Optional feature macro: RESULT_FRAME_CHECKSUM_EN
//   When defined, a checksum byte (XOR of LEN, CMD_RES and all data bytes)
//   is sent between the last data byte and the footer. LEN is unchanged.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   clear      in   synchronous abort/flush (returns to IDLE, clears cfg_err)
//   N          in   results per frame, sampled on the first accepted result
//   res_valid  in   processor result valid
//   res_data   in   processor result byte
//   res_ready  out  block can accept a result
//   tx_valid   out  tx_data valid toward UART TX
//   tx_data    out  byte to transmit
//   tx_ready   in   UART TX accepts the byte when tx_valid && tx_ready
//   busy       out  high whenever the FSM is not in IDLE
//   frame_done out  one-cycle pulse after the footer byte is accepted
//   cfg_err    out  sticky flag for an illegal N (0 or > MAX_N)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module result_frame_tx #(
  parameter int             DW      = 8,
  parameter int             MAX_N   = 8,
  parameter logic [DW-1:0]  HDR     = 8'hFE,
  parameter logic [DW-1:0]  FTR     = 8'hEF,
  parameter logic [DW-1:0]  CMD_RES = 8'h03
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [3:0]    N,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          res_ready,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  // Buffer index width; MAX_N must be >= 2 and <= 15 (N is a 4-bit port).
  localparam int         IW      = $clog2(MAX_N);
  localparam logic [3:0] MAX_N_L = 4'(MAX_N);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    S_HDR   = 3'd2,
    S_LEN   = 3'd3,
    S_CMD   = 3'd4,
    S_DATA  = 3'd5,
    S_FTR   = 3'd6
`ifdef RESULT_FRAME_CHECKSUM_EN
    , S_CSUM = 3'd7
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  buf_q [MAX_N];
  logic [DW-1:0]  buf_d [MAX_N];
  logic [3:0]     n_lat_q, n_lat_d;
  logic [3:0]     wr_cnt_q, wr_cnt_d;
  logic [3:0]     rd_idx_q, rd_idx_d;
  logic           res_ready_q, res_ready_d;
  logic           tx_valid_q, tx_valid_d;
  logic [DW-1:0]  tx_data_q, tx_data_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic           cfg_err_q, cfg_err_d;
`ifdef RESULT_FRAME_CHECKSUM_EN
  logic [DW-1:0]  csum_q, csum_d;
`endif

  logic           res_fire_s;
  logic           tx_fire_s;
  logic [DW-1:0]  len_byte_s;
  logic [IW-1:0]  rd_nxt_s;

  assign res_fire_s = res_valid & res_ready_q;
  assign tx_fire_s  = tx_valid_q & tx_ready;
  assign len_byte_s = {{(DW-4){1'b0}}, n_lat_q} + {{(DW-1){1'b0}}, 1'b1};
  assign rd_nxt_s   = rd_idx_q[IW-1:0] + IW'(1);

  // Next-state and next-output computation for the whole FSM.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    n_lat_d      = n_lat_q;
    wr_cnt_d     = wr_cnt_q;
    rd_idx_d     = rd_idx_q;
    tx_data_d    = tx_data_q;
    cfg_err_d    = cfg_err_q;
    frame_done_d = 1'b0;
`ifdef RESULT_FRAME_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (clear) begin
      // Abort: flush everything; a pending result in this cycle is dropped.
      state_d   = IDLE;
      for (int i = 0; i < MAX_N; i++) begin
        buf_d[i] = '0;
      end
      n_lat_d   = 4'd0;
      wr_cnt_d  = 4'd0;
      rd_idx_d  = 4'd0;
      tx_data_d = '0;
      cfg_err_d = 1'b0;
`ifdef RESULT_FRAME_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (res_fire_s) begin
            if (cfg_err_q) begin
              // Sticky error: swallow results until a clear.
              state_d = IDLE;
            end else if ((N == 4'd0) || (N > MAX_N_L)) begin
              n_lat_d   = N;
              cfg_err_d = 1'b1;
            end else begin
              n_lat_d  = N;
              buf_d[0] = res_data;
              wr_cnt_d = 4'd1;
              if (N == 4'd1) begin
                state_d   = S_HDR;
                tx_data_d = HDR;
              end else begin
                state_d = COLLECT;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end

        COLLECT: begin
          if (res_fire_s) begin
            buf_d[wr_cnt_q[IW-1:0]] = res_data;
            wr_cnt_d                = wr_cnt_q + 4'd1;
            if ((wr_cnt_q + 4'd1) == n_lat_q) begin
              state_d   = S_HDR;
              tx_data_d = HDR;
            end else begin
              state_d = COLLECT;
            end
          end else begin
            state_d = COLLECT;
          end
        end

        S_HDR: begin
          if (tx_fire_s) begin
            state_d   = S_LEN;
            tx_data_d = len_byte_s;
`ifdef RESULT_FRAME_CHECKSUM_EN
            csum_d    = '0;
`endif
          end else begin
            state_d = S_HDR;
          end
        end

        S_LEN: begin
          if (tx_fire_s) begin
            state_d   = S_CMD;
            tx_data_d = CMD_RES;
`ifdef RESULT_FRAME_CHECKSUM_EN
            csum_d    = csum_q ^ tx_data_q;
`endif
          end else begin
            state_d = S_LEN;
          end
        end

        S_CMD: begin
          if (tx_fire_s) begin
            state_d   = S_DATA;
            rd_idx_d  = 4'd0;
            tx_data_d = buf_q[0];
`ifdef RESULT_FRAME_CHECKSUM_EN
            csum_d    = csum_q ^ tx_data_q;
`endif
          end else begin
            state_d = S_CMD;
          end
        end

        S_DATA: begin
          if (tx_fire_s) begin
`ifdef RESULT_FRAME_CHECKSUM_EN
            csum_d = csum_q ^ tx_data_q;
`endif
            if (rd_idx_q == (n_lat_q - 4'd1)) begin
              rd_idx_d = 4'd0;
`ifdef RESULT_FRAME_CHECKSUM_EN
              // Last data byte is still on tx_data_q, fold it in directly.
              state_d   = S_CSUM;
              tx_data_d = csum_q ^ tx_data_q;
`else
              state_d   = S_FTR;
              tx_data_d = FTR;
`endif
            end else begin
              state_d   = S_DATA;
              rd_idx_d  = rd_idx_q + 4'd1;
              tx_data_d = buf_q[rd_nxt_s];
            end
          end else begin
            state_d = S_DATA;
          end
        end

`ifdef RESULT_FRAME_CHECKSUM_EN
        S_CSUM: begin
          if (tx_fire_s) begin
            state_d   = S_FTR;
            tx_data_d = FTR;
          end else begin
            state_d = S_CSUM;
          end
        end
`endif

        S_FTR: begin
          if (tx_fire_s) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            n_lat_d      = 4'd0;
            wr_cnt_d     = 4'd0;
            rd_idx_d     = 4'd0;
            tx_data_d    = '0;
          end else begin
            state_d = S_FTR;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean IDLE.
          state_d   = IDLE;
          n_lat_d   = 4'd0;
          wr_cnt_d  = 4'd0;
          rd_idx_d  = 4'd0;
          tx_data_d = '0;
        end
      endcase
    end

    // Handshake outputs follow directly from the next state.
    res_ready_d = (state_d == IDLE) || (state_d == COLLECT);
    tx_valid_d  = !((state_d == IDLE) || (state_d == COLLECT));
    busy_d      = (state_d != IDLE);
  end

  // State, buffer and registered outputs; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < MAX_N; i++) begin
        buf_q[i] <= '0;
      end
      n_lat_q      <= 4'd0;
      wr_cnt_q     <= 4'd0;
      rd_idx_q     <= 4'd0;
      res_ready_q  <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
`ifdef RESULT_FRAME_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      n_lat_q      <= n_lat_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_idx_q     <= rd_idx_d;
      res_ready_q  <= res_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
`ifdef RESULT_FRAME_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign res_ready  = res_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_result_frame_tx.sv
`timescale 1ns/1ps
module tb_result_frame_tx;

  localparam logic [7:0] HDR = 8'hFE;
  localparam logic [7:0] FTR = 8'hEF;
  localparam logic [7:0] CMD = 8'h03;
`ifdef RESULT_FRAME_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [3:0] N;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       frame_done;
  logic       cfg_err;

  result_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .N          (N),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] q[$];
  logic       res_fire;
  int         pops = 0;

  typedef struct {
    logic [3:0]  n;
    logic [63:0] d;        // byte i at d[8*i +: 8]
    int          bp;       // 0: ready high, 1: 1-0-0-1 pattern, 2: random
    logic [7:0]  exp_len;
    int          exp_cyc;  // tx_valid cycles without checksum, ready high
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: score TX bytes / result transfers before the edge, check hold after.
  task automatic cycle();
    logic       stall;
    logic [7:0] held;
    logic [7:0] e;
    res_fire = rst && !clear && res_valid && res_ready;
    stall    = rst && !clear && tx_valid && !tx_ready;
    held     = tx_data;
    if (rst && !clear && tx_valid && tx_ready) begin
      pops++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_extra got=%0h exp=none at %0t", tx_data, $time);
      end else begin
        e = q.pop_front();
        chk("tx_byte", 32'(tx_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (stall) begin
      chk("tx_hold_data", 32'(tx_data), 32'(held));
      chk("tx_hold_valid", 32'(tx_valid), 32'd1);
    end
  endtask

  task automatic push_expected(input logic [3:0] n, input logic [63:0] d, input logic [7:0] len);
    logic [7:0] cs;
    logic [7:0] b;
    q.push_back(HDR);
    q.push_back(len);
    q.push_back(CMD);
    cs = len ^ CMD;
    for (int i = 0; i < int'(n); i++) begin
      b = d[8*i +: 8];
      q.push_back(b);
      cs = cs ^ b;
    end
`ifdef RESULT_FRAME_CHECKSUM_EN
    q.push_back(cs);
`endif
    q.push_back(FTR);
  endtask

  task automatic feed(input logic [3:0] n, input logic [63:0] d);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    N     = n;
    while (sent < int'(n) && guard < 50) begin
      res_valid = 1'b1;
      res_data  = d[8*sent +: 8];
      cycle();
      if (res_fire) sent++;
      guard++;
    end
    res_valid = 1'b0;
    res_data  = 8'h00;
    chk("feed_done", 32'(sent), 32'(n));
  endtask

  task automatic drain(input int bp, input int exp_cyc);
    logic [3:0] pat;
    int vcyc;
    int fd;
    int guard;
    int rr_bad;
    pat    = 4'b1001;
    vcyc   = 0;
    fd     = 0;
    guard  = 0;
    rr_bad = 0;
    while (fd == 0 && guard < 300) begin
      if (bp == 0)      tx_ready = 1'b1;
      else if (bp == 1) tx_ready = pat[guard[1:0]];
      else              tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid) vcyc++;
      if (tx_valid && res_ready) rr_bad++;
      cycle();
      guard++;
      if (frame_done) fd = 1;
    end
    chk("frame_done_seen", 32'(fd), 32'd1);
    chk("res_ready_low_during_send", 32'(rr_bad), 32'd0);
    chk("res_ready_after_ftr", 32'(res_ready), 32'd1);
    chk("tx_valid_after_ftr", 32'(tx_valid), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    if (bp == 0) chk("frame_cycles", 32'(vcyc), 32'(exp_cyc + CS_EXTRA));
    tx_ready = 1'b1;
    cycle();
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    push_expected(v.n, v.d, v.exp_len);
    tx_ready = 1'b1;
    feed(v.n, v.d);
    chk("first_tx_latency", 32'(tx_valid), 32'd1);
    chk("busy_send", 32'(busy), 32'd1);
    chk("res_ready_send", 32'(res_ready), 32'd0);
    drain(v.bp, v.exp_cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 4'd3, d: 64'h0000_0000_0033_2211, bp: 0, exp_len: 8'h04, exp_cyc: 7};
    tbl[1] = '{n: 4'd2, d: 64'h0000_0000_0000_5AA5, bp: 1, exp_len: 8'h03, exp_cyc: 6};
    tbl[2] = '{n: 4'd1, d: 64'h0000_0000_0000_007F, bp: 0, exp_len: 8'h02, exp_cyc: 5};
    tbl[3] = '{n: 4'd8, d: 64'hC396_01FF_807E_005A, bp: 0, exp_len: 8'h09, exp_cyc: 12};
    tbl[4] = '{n: 4'd2, d: 64'h0000_0000_0000_F00F, bp: 0, exp_len: 8'h03, exp_cyc: 6};
    tbl[5] = '{n: 4'd5, d: 64'h0000_00EE_DDCC_BBAA, bp: 2, exp_len: 8'h06, exp_cyc: 9};

    // Reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clear     = 1'($urandom_range(0, 1));
      N         = 4'($urandom_range(0, 15));
      res_valid = 1'($urandom_range(0, 1));
      res_data  = 8'($urandom);
      tx_ready  = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("rst_res_ready", 32'(res_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    clear = 1'b0; res_valid = 1'b0; res_data = 8'h00; N = 4'd0; tx_ready = 1'b1;
    rst = 1'b1;
    cycle();

    // Table-driven frames
    for (int t = 0; t < 6; t++) begin
      run_frame(tbl[t]);
    end

    // Illegal N = 0, then N = 9 while the error is sticky
    N = 4'd0; res_valid = 1'b1; res_data = 8'h55;
    cycle();
    res_valid = 1'b0;
    chk("err_n0_cfg_err", 32'(cfg_err), 32'd1);
    chk("err_n0_tx_valid", 32'(tx_valid), 32'd0);
    chk("err_n0_busy", 32'(busy), 32'd0);
    chk("err_n0_res_ready", 32'(res_ready), 32'd1);
    N = 4'd9; res_valid = 1'b1; res_data = 8'h66;
    cycle();
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("err_n9_cfg_err", 32'(cfg_err), 32'd1);
    chk("err_n9_tx_valid", 32'(tx_valid), 32'd0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("err_cleared", 32'(cfg_err), 32'd0);
    run_frame(tbl[2]);

    // Illegal N = 9 first
    N = 4'd9; res_valid = 1'b1; res_data = 8'h01;
    cycle();
    res_valid = 1'b0;
    chk("err_n9_first", 32'(cfg_err), 32'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;

    // Clear wins over a simultaneous result
    N = 4'd1; res_valid = 1'b1; res_data = 8'h99; clear = 1'b1;
    cycle();
    clear = 1'b0; res_valid = 1'b0;
    cycle();
    chk("clear_drop_busy", 32'(busy), 32'd0);
    chk("clear_drop_tx_valid", 32'(tx_valid), 32'd0);

    // Abort during data after two data bytes
    begin
      int start;
      int guard;
      push_expected(4'd4, 64'h0000_0000_4433_2211, 8'h05);
      tx_ready = 1'b1;
      feed(4'd4, 64'h0000_0000_4433_2211);
      start = pops;
      guard = 0;
      while (pops < start + 5 && guard < 50) begin
        cycle();
        guard++;
      end
      chk("abort_reached_data", 32'(pops - start), 32'd5);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("abort_tx_valid", 32'(tx_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_res_ready", 32'(res_ready), 32'd1);
      chk("abort_no_done", 32'(frame_done), 32'd0);
      q.delete();
      cycle();
      chk("abort_no_done_later", 32'(frame_done), 32'd0);
      run_frame(tbl[2]);
    end

    // Reset in the middle of a stalled send
    tx_ready = 1'b0;
    feed(4'd2, 64'h0000_0000_0000_BEEF);
    cycle();
    rst = 1'b0; clear = 1'b1;
    cycle();
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_ready", 32'(res_ready), 32'd1);
    rst = 1'b1; clear = 1'b0;
    cycle();
    run_frame(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
